// File: rtl/router_sync_n_pkg.sv
// router_pkg: shared defaults and width helpers for the router sync stage.
package router_pkg;
  localparam int ROUTER_NUM_CH = 3;
  localparam int ROUTER_TIMEOUT = 30;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int addr_w(input int n);
    return (clog2(n) > 1) ? clog2(n) : 1;
  endfunction
  typedef logic [addr_w(ROUTER_NUM_CH)-1:0] ch_idx_t;
endpackage

// File: rtl/router_sync_n_if.sv
// router_sync_n_if: FSM/FIFO-side signals of the sync stage; master drives, slave is the sync block.
// ROUTER_SYNC_TIMEOUT_STATUS_EN adds clr_status/timeout_status.
interface router_sync_n_if import router_pkg::*; #(parameter int NUM_CH = ROUTER_NUM_CH);
  localparam int ADDR_W = addr_w(NUM_CH);
  logic              detect_add;
  logic [ADDR_W-1:0] data_in;
  logic              write_enb_reg;
  logic [NUM_CH-1:0] read_enb;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] vld_out;
  logic [NUM_CH-1:0] soft_reset;
  logic              fifo_full;
  logic [NUM_CH-1:0] write_enb;
  logic              addr_err;
`ifdef ROUTER_SYNC_TIMEOUT_STATUS_EN
  logic              clr_status;
  logic [NUM_CH-1:0] timeout_status;
`endif
  modport master (
    output detect_add, data_in, write_enb_reg, read_enb, empty, full,
    input  vld_out, soft_reset, fifo_full, write_enb, addr_err
`ifdef ROUTER_SYNC_TIMEOUT_STATUS_EN
    , output clr_status, input timeout_status
`endif
  );
  modport slave (
    input  detect_add, data_in, write_enb_reg, read_enb, empty, full,
    output vld_out, soft_reset, fifo_full, write_enb, addr_err
`ifdef ROUTER_SYNC_TIMEOUT_STATUS_EN
    , input clr_status, output timeout_status
`endif
  );
endinterface

// File: rtl/router_sync_n_timer.sv
// router_sync_timer: one channel's read-timeout counter and registered soft_reset pulse.
// ROUTER_SYNC_TIMEOUT_STATUS_EN adds a sticky timeout_status flop.
module router_sync_timer import router_pkg::*; #(
  parameter int TIMEOUT = ROUTER_TIMEOUT
) (
  input  logic clock,
  input  logic resetn,
  input  logic vld,
  input  logic read,
  output logic soft_reset
`ifdef ROUTER_SYNC_TIMEOUT_STATUS_EN
  , input  logic clr_status
  , output logic timeout_status
`endif
);
  localparam int CNT_W = clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;
  logic cnt_en, hit;
  assign cnt_en = vld & ~read;
  assign hit = cnt_en && (cnt == CNT_W'(TIMEOUT - 1));
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else begin
      cnt        <= (cnt_en && !hit) ? cnt + CNT_W'(1) : '0;
      soft_reset <= hit;
    end
`ifdef ROUTER_SYNC_TIMEOUT_STATUS_EN
  // set wins over a simultaneous clear
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) timeout_status <= 1'b0;
    else timeout_status <= hit | (timeout_status & ~clr_status);
`endif
endmodule

// File: rtl/router_sync_n.sv
// router_sync_n: header address latch/decode, addressed full mux, per-channel read timeouts.
// Optional ROUTER_SYNC_TIMEOUT_STATUS_EN adds sticky per-channel timeout status.
module router_sync_n import router_pkg::*; #(
  parameter int NUM_CH  = ROUTER_NUM_CH,
  parameter int TIMEOUT = ROUTER_TIMEOUT
) (
  input logic clock,
  input logic resetn,
  router_sync_n_if.slave bus
);
  localparam int ADDR_W = addr_w(NUM_CH);
  logic [ADDR_W-1:0] addr_q;
  logic addr_valid, addr_seen;
  logic [NUM_CH-1:0] sr;
`ifdef ROUTER_SYNC_TIMEOUT_STATUS_EN
  logic [NUM_CH-1:0] st;
  assign bus.timeout_status = st;
`endif
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      addr_q     <= '0;
      addr_valid <= 1'b0;
      addr_seen  <= 1'b0;
    end else if (bus.detect_add) begin
      addr_q     <= bus.data_in;
      addr_valid <= {1'b0, bus.data_in} < (ADDR_W + 1)'(NUM_CH);
      addr_seen  <= 1'b1;
    end
  // out-of-range addr_q only reaches full[] while addr_valid masks it
  assign bus.write_enb  = (bus.write_enb_reg && addr_valid) ? NUM_CH'(1) << addr_q : '0;
  assign bus.fifo_full  = addr_valid & bus.full[addr_q];
  assign bus.vld_out    = ~bus.empty;
  assign bus.addr_err   = ~addr_valid & addr_seen;
  assign bus.soft_reset = sr;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    router_sync_timer #(.TIMEOUT(TIMEOUT)) u_tmr (
      .clock          (clock),
      .resetn         (resetn),
      .vld            (~bus.empty[i]),
      .read           (bus.read_enb[i]),
      .soft_reset     (sr[i])
`ifdef ROUTER_SYNC_TIMEOUT_STATUS_EN
      , .clr_status     (bus.clr_status)
      , .timeout_status (st[i])
`endif
    );
  end
endmodule
